// File: rtl/pcnt.sv
// Programmable up/down counter with prescaler, runtime limits and SATURATE/ROLL/PINGPONG limit policies.
// Outputs q, dir_q, tc and cmp_hit are registered; at_lim and cfg_err are combinational views of state.
module pcnt #(
    parameter int               WIDTH = 8,
    parameter string            MODE  = "ROLL",
    parameter int               PRE_W = 8,
    parameter logic [WIDTH-1:0] START = '0
) (
    input  logic             clk,
    input  logic             sclr,
    input  logic             ena,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             dir,
    input  logic [WIDTH-1:0] min,
    input  logic [WIDTH-1:0] max,
    input  logic [WIDTH-1:0] step,
    input  logic [PRE_W-1:0] presc,
    input  logic [WIDTH-1:0] cmp,
    output logic [WIDTH-1:0] q,
    output logic             dir_q,
    output logic             at_lim,
    output logic             tc,
    output logic             cmp_hit,
    output logic             cfg_err
);

    localparam logic [1:0] MODE_SAT  = 2'd0;
    localparam logic [1:0] MODE_ROLL = 2'd1;
    localparam logic [1:0] MODE_PP   = 2'd2;
    localparam logic [1:0] MODE_SEL  = (MODE == "SATURATE") ? MODE_SAT :
                                       (MODE == "PINGPONG") ? MODE_PP  : MODE_ROLL;

    logic [WIDTH-1:0] q_r;
    logic             dir_r;
    logic             tc_r;
    logic             cmp_hit_r;
    logic [PRE_W-1:0] pre_r;

    logic [WIDTH-1:0] q_nxt_s;
    logic             dir_nxt_s;
    logic             tc_nxt_s;
    logic [PRE_W-1:0] pre_nxt_s;

    logic             tick_s;
    logic             at_lim_s;
    logic             cfg_err_s;
    logic [WIDTH:0]   up_sum_s;
    logic [WIDTH:0]   dn_lim_s;
    logic [WIDTH-1:0] up_val_s;
    logic [WIDTH-1:0] dn_val_s;

    // Tick, limit status and clamped one-step candidates in both directions.
    always_comb begin
        tick_s    = ena && (pre_r == presc);
        cfg_err_s = (min > max);
        at_lim_s  = dir_r ? (q_r >= max) : (q_r <= min);
        // Widened by one bit so q+step and min+step never wrap before the clamp compare.
        up_sum_s  = {1'b0, q_r} + {1'b0, step};
        dn_lim_s  = {1'b0, min} + {1'b0, step};
        up_val_s  = (up_sum_s > {1'b0, max}) ? max : up_sum_s[WIDTH-1:0];
        dn_val_s  = ({1'b0, q_r} < dn_lim_s) ? min : (q_r - step);
    end

    // Next-state selection: load beats tick beats hold.
    always_comb begin
        q_nxt_s   = q_r;
        dir_nxt_s = (MODE_SEL == MODE_PP) ? dir_r : dir;
        tc_nxt_s  = 1'b0;
        pre_nxt_s = pre_r;
        if (load) begin
            q_nxt_s   = data;
            pre_nxt_s = '0;
        end else begin
            if (ena) begin
                pre_nxt_s = tick_s ? '0 : (pre_r + {{(PRE_W-1){1'b0}}, 1'b1});
            end else begin
                pre_nxt_s = pre_r;
            end
            if (tick_s && !cfg_err_s) begin
                if (!at_lim_s) begin
                    q_nxt_s  = dir_r ? up_val_s : dn_val_s;
                    tc_nxt_s = (MODE_SEL == MODE_SAT) &&
                               (dir_r ? (up_val_s >= max) : (dn_val_s <= min));
                end else begin
                    case (MODE_SEL)
                        MODE_SAT: begin
                            q_nxt_s  = q_r;
                            tc_nxt_s = 1'b0;
                        end
                        MODE_ROLL: begin
                            q_nxt_s  = dir_r ? min : max;
                            tc_nxt_s = 1'b1;
                        end
                        MODE_PP: begin
                            // Reverse, then step in the new direction with normal clamping.
                            dir_nxt_s = ~dir_r;
                            q_nxt_s   = dir_r ? dn_val_s : up_val_s;
                            tc_nxt_s  = 1'b1;
                        end
                        default: begin
                            q_nxt_s  = q_r;
                            tc_nxt_s = 1'b0;
                        end
                    endcase
                end
            end else begin
                q_nxt_s = q_r;
            end
        end
    end

    // State register with synchronous clear.
    always_ff @(posedge clk) begin
        if (sclr) begin
            q_r       <= START;
            pre_r     <= '0;
            dir_r     <= dir;
            tc_r      <= 1'b0;
            cmp_hit_r <= 1'b0;
        end else begin
            q_r       <= q_nxt_s;
            pre_r     <= pre_nxt_s;
            dir_r     <= dir_nxt_s;
            tc_r      <= tc_nxt_s;
            cmp_hit_r <= (q_r == cmp);
        end
    end

    assign q       = q_r;
    assign dir_q   = dir_r;
    assign tc      = tc_r;
    assign cmp_hit = cmp_hit_r;
    assign at_lim  = at_lim_s;
    assign cfg_err = cfg_err_s;

endmodule

// File: tb/tb_pcnt.sv
// Self-checking bench for pcnt: one instance per limit policy, driven in parallel and compared
// every cycle against an integer reference model, plus directed sequences with literal expectations.
module tb_pcnt;

    logic       clk;
    logic       sclr, ena, load, dir;
    logic [7:0] data, lo, hi, step, presc, cmp;

    logic [7:0] q_o   [3];
    logic       dir_o [3];
    logic       at_o  [3];
    logic       tc_o  [3];
    logic       hit_o [3];
    logic       cfg_o [3];

    int checks = 0;
    int errors = 0;

    // Instance 0 = ROLL (START 2), 1 = PINGPONG, 2 = SATURATE; model mode codes 1, 2, 0.
    int mode_v  [3] = '{1, 2, 0};
    int start_v [3] = '{2, 0, 0};
    int m_q   [3];
    int m_pre [3];
    bit m_dir [3];
    bit m_tc  [3];
    bit m_hit [3];

    int e037 [5] = '{3, 4, 5, 2, 3};
    int e038 [7] = '{4, 8, 10, 6, 2, 0, 4};
    int d038 [7] = '{1, 1, 1, 0, 0, 0, 1};
    int e039 [5] = '{6, 4, 3, 3, 3};

    pcnt #(.WIDTH(8), .MODE("ROLL"), .PRE_W(8), .START(8'd2)) u_roll (
        .clk(clk), .sclr(sclr), .ena(ena), .load(load), .data(data), .dir(dir),
        .min(lo), .max(hi), .step(step), .presc(presc), .cmp(cmp),
        .q(q_o[0]), .dir_q(dir_o[0]), .at_lim(at_o[0]), .tc(tc_o[0]),
        .cmp_hit(hit_o[0]), .cfg_err(cfg_o[0]));

    pcnt #(.WIDTH(8), .MODE("PINGPONG"), .PRE_W(8), .START(8'd0)) u_pp (
        .clk(clk), .sclr(sclr), .ena(ena), .load(load), .data(data), .dir(dir),
        .min(lo), .max(hi), .step(step), .presc(presc), .cmp(cmp),
        .q(q_o[1]), .dir_q(dir_o[1]), .at_lim(at_o[1]), .tc(tc_o[1]),
        .cmp_hit(hit_o[1]), .cfg_err(cfg_o[1]));

    pcnt #(.WIDTH(8), .MODE("SATURATE"), .PRE_W(8), .START(8'd0)) u_sat (
        .clk(clk), .sclr(sclr), .ena(ena), .load(load), .data(data), .dir(dir),
        .min(lo), .max(hi), .step(step), .presc(presc), .cmp(cmp),
        .q(q_o[2]), .dir_q(dir_o[2]), .at_lim(at_o[2]), .tc(tc_o[2]),
        .cmp_hit(hit_o[2]), .cfg_err(cfg_o[2]));

    always #5 clk = ~clk;

    function automatic int up_clamp(input int v, input int s, input int h);
        return (v + s > h) ? h : v + s;
    endfunction

    function automatic int dn_clamp(input int v, input int s, input int l);
        return (v - s < l) ? l : v - s;
    endfunction

    task automatic chk(input string tag, input int k, input logic [31:0] got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, k, got, exp);
        end
    endtask

    // One clock: predict every instance's next state, advance, then compare all outputs.
    task automatic step_clk();
        int nq [3];
        int np [3];
        bit nd [3];
        bit nt [3];
        bit nh [3];
        bit tk, at, ndir;
        int l, h, s;
        l = int'(lo);
        h = int'(hi);
        s = int'(step);
        for (int k = 0; k < 3; k++) begin
            tk    = ena && (m_pre[k] == int'(presc));
            at    = m_dir[k] ? (m_q[k] >= h) : (m_q[k] <= l);
            nq[k] = m_q[k];
            nd[k] = (mode_v[k] == 2) ? m_dir[k] : dir;
            nt[k] = 1'b0;
            nh[k] = (m_q[k] == int'(cmp));
            np[k] = ena ? (tk ? 0 : (m_pre[k] + 1) % 256) : m_pre[k];
            if (sclr) begin
                nq[k] = start_v[k];
                nd[k] = dir;
                nh[k] = 1'b0;
                np[k] = 0;
            end else if (load) begin
                nq[k] = int'(data);
                np[k] = 0;
            end else if (tk && l <= h) begin
                if (!at) begin
                    nq[k] = m_dir[k] ? up_clamp(m_q[k], s, h) : dn_clamp(m_q[k], s, l);
                    nt[k] = (mode_v[k] == 0) && (m_dir[k] ? (nq[k] >= h) : (nq[k] <= l));
                end else if (mode_v[k] == 1) begin
                    nq[k] = m_dir[k] ? l : h;
                    nt[k] = 1'b1;
                end else if (mode_v[k] == 2) begin
                    ndir  = !m_dir[k];
                    nd[k] = ndir;
                    nq[k] = ndir ? up_clamp(m_q[k], s, h) : dn_clamp(m_q[k], s, l);
                    nt[k] = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            m_q[k]   = nq[k];
            m_pre[k] = np[k];
            m_dir[k] = nd[k];
            m_tc[k]  = nt[k];
            m_hit[k] = nh[k];
            chk("q", k, q_o[k], m_q[k]);
            chk("dir_q", k, dir_o[k], m_dir[k]);
            chk("tc", k, tc_o[k], m_tc[k]);
            chk("cmp_hit", k, hit_o[k], m_hit[k]);
            chk("at_lim", k, at_o[k], m_dir[k] ? (m_q[k] >= h) : (m_q[k] <= l));
            chk("cfg_err", k, cfg_o[k], (l > h) ? 1 : 0);
        end
    endtask

    initial begin
        clk = 1'b0;
        for (int k = 0; k < 3; k++) begin
            m_q[k] = 0; m_pre[k] = 0; m_dir[k] = 1'b0; m_tc[k] = 1'b0; m_hit[k] = 1'b0;
        end
        sclr = 1'b1; ena = 1'b0; load = 1'b0; dir = 1'b1; data = 8'd0;
        lo = 8'd2; hi = 8'd5; step = 8'd1; presc = 8'd0; cmp = 8'd0;

        // Reset state.
        step_clk();
        chk("rst_q", 0, q_o[0], 2);
        chk("rst_q", 1, q_o[1], 0);
        chk("rst_q", 2, q_o[2], 0);
        for (int k = 0; k < 3; k++) begin
            chk("rst_tc", k, tc_o[k], 0);
            chk("rst_hit", k, hit_o[k], 0);
        end

        // ROLL 2..5 wrap.
        sclr = 1'b0; ena = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step_clk();
            chk("roll_q", 0, q_o[0], e037[i]);
            chk("roll_tc", 0, tc_o[0], (i == 3) ? 1 : 0);
        end

        // PINGPONG 0..10 step 4.
        sclr = 1'b1; lo = 8'd0; hi = 8'd10; step = 8'd4; dir = 1'b1;
        step_clk();
        chk("pp_start", 1, q_o[1], 0);
        sclr = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step_clk();
            chk("pp_q", 1, q_o[1], e038[i]);
            chk("pp_dir", 1, dir_o[1], d038[i]);
            chk("pp_tc", 1, tc_o[1], (i == 3 || i == 6) ? 1 : 0);
        end

        // SATURATE down onto min=3 after load of 8.
        dir = 1'b0; lo = 8'd3; hi = 8'd255; step = 8'd2; load = 1'b1; data = 8'd8;
        step_clk();
        chk("sat_load", 2, q_o[2], 8);
        load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step_clk();
            chk("sat_q", 2, q_o[2], e039[i]);
            chk("sat_tc", 2, tc_o[2], (i == 2) ? 1 : 0);
        end

        // Prescaler divide-by-3 and ena gating.
        sclr = 1'b1; dir = 1'b1; lo = 8'd0; hi = 8'd255; step = 8'd1; presc = 8'd2; ena = 1'b0;
        step_clk();
        sclr = 1'b0; ena = 1'b1;
        repeat (9) step_clk();
        chk("presc_9", 2, q_o[2], 3);
        step_clk();
        ena = 1'b0;
        repeat (2) begin
            step_clk();
            chk("presc_hold", 2, q_o[2], 3);
        end
        ena = 1'b1;
        step_clk();
        chk("presc_resume", 2, q_o[2], 3);
        step_clk();
        chk("presc_tick", 2, q_o[2], 4);

        // sclr beats load; inverted limits freeze counting.
        presc = 8'd0;
        repeat (3) step_clk();
        sclr = 1'b1; load = 1'b1; data = 8'd77;
        step_clk();
        for (int k = 0; k < 3; k++) begin
            chk("sclr_load_q", k, q_o[k], start_v[k]);
            chk("sclr_load_tc", k, tc_o[k], 0);
        end
        sclr = 1'b0; load = 1'b0; lo = 8'd9; hi = 8'd4;
        repeat (4) begin
            step_clk();
            for (int k = 0; k < 3; k++) begin
                chk("cfg_frozen", k, q_o[k], start_v[k]);
                chk("cfg_err_set", k, cfg_o[k], 1);
                chk("cfg_tc", k, tc_o[k], 0);
            end
        end

        // ROLL full range: clamp at 255 without 9-bit wrap, then roll to 0.
        lo = 8'd0; hi = 8'd255; dir = 1'b1; step = 8'd10; load = 1'b1; data = 8'd250;
        step_clk();
        chk("wide_load", 0, q_o[0], 250);
        load = 1'b0;
        step_clk();
        chk("wide_clamp", 0, q_o[0], 255);
        chk("wide_clamp_tc", 0, tc_o[0], 0);
        step_clk();
        chk("wide_roll", 0, q_o[0], 0);
        chk("wide_roll_tc", 0, tc_o[0], 1);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            if (n % 16 == 0) begin
                lo    = 8'($urandom_range(0, 120));
                hi    = 8'($urandom_range(100, 255));
                step  = 8'($urandom_range(0, 40));
                presc = 8'($urandom_range(0, 3));
            end
            sclr = ($urandom_range(0, 49) == 0);
            load = ($urandom_range(0, 19) == 0);
            ena  = ($urandom_range(0, 3) != 0);
            dir  = 1'($urandom_range(0, 1));
            data = 8'($urandom_range(0, 255));
            cmp  = ($urandom_range(0, 1) == 1) ? 8'(m_q[$urandom_range(0, 2)])
                                               : 8'($urandom_range(0, 255));
            step_clk();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
